// File: rtl/proyecto3_system_timer_ctrl_if.sv
// Avalon-MM link to the interval-timer slave: 16-bit data, 3-bit word address,
// registered readdata, level irq.
interface proyecto3_system_timer_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/proyecto3_system_timer_ctrl.sv
// Timer sequencer: programs the interval timer, services its irq and takes
// atomic counter snapshots on behalf of the application logic.
//
// state      | meaning
// IDLE       | timer stopped, waiting for start or snap_req
// WR_PL      | write period[15:0] to addr 2
// WR_PH      | write period[31:16] to addr 3
// WR_CTRL    | write START/CONT/ITO to control
// RUN        | timer running, waiting for stop/start/irq/snap_req
// CLR_ST     | clear status (acknowledge irq), tick pulse
// WR_STOP    | write STOP to control
// SNAP_WR    | write snapl to latch the live counter
// SNAP_RL    | read snapl
// SNAP_RH    | read snaph, capture low half
// SNAP_DONE  | capture high half, snap_valid pulse
module proyecto3_system_timer_ctrl #(
  parameter int   TICK_W   = 16,
  parameter logic CTRL_ITO = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [31:0]           period,
  input  logic                  continuous,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_W-1:0]     tick_count,
  output logic [31:0]           snap_value,
  output logic                  snap_valid,
  output logic                  err,
  proyecto3_system_timer_ctrl_if.master tmr
);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR_ST,
    S_WR_STOP, S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_DONE
  } state_t;

  state_t      state, state_n;
  logic [31:0] period_q;
  logic        cont_q;
  logic        stop_pend;
  logic        from_run, from_run_n;
  logic [15:0] snap_lo;
  logic [31:0] snap_q;
  logic        err_n;
  logic        latch;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      period_q   <= '0;
      cont_q     <= 1'b0;
      stop_pend  <= 1'b0;
      from_run   <= 1'b0;
      tick_count <= '0;
      snap_lo    <= '0;
      snap_q     <= '0;
      err        <= 1'b0;
    end else begin
      state    <= state_n;
      from_run <= from_run_n;
      err      <= err_n;
      if (latch) begin
        period_q <= period;
        cont_q   <= continuous;
      end
      // A stop already being executed makes a concurrent stop redundant.
      if (state == S_WR_STOP)
        stop_pend <= 1'b0;
      else if (busy && stop)
        stop_pend <= 1'b1;
      if (state == S_CLR_ST)
        tick_count <= tick_count + TICK_W'(1);
      if (state == S_SNAP_RH)
        snap_lo <= tmr.readdata;
      if (state == S_SNAP_DONE)
        snap_q <= {tmr.readdata, snap_lo};
    end
  end

  always_comb begin
    state_n    = state;
    from_run_n = from_run;
    err_n      = 1'b0;
    latch      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (period == 32'd0) begin
            err_n = 1'b1;
          end else begin
            latch   = 1'b1;
            state_n = S_WR_PL;
          end
        end else if (snap_req) begin
          from_run_n = 1'b0;
          state_n    = S_SNAP_WR;
        end
      end
      S_RUN: begin
        if (stop || stop_pend) begin
          state_n = S_WR_STOP;
        end else if (start) begin
          if (period == 32'd0) begin
            err_n = 1'b1;
          end else begin
            latch   = 1'b1;
            state_n = S_WR_PL;
          end
        end else if (tmr.irq) begin
          state_n = S_CLR_ST;
        end else if (snap_req) begin
          from_run_n = 1'b1;
          state_n    = S_SNAP_WR;
        end
      end
      S_WR_PL:     state_n = S_WR_PH;
      S_WR_PH:     state_n = S_WR_CTRL;
      S_WR_CTRL:   state_n = S_RUN;
      S_CLR_ST:    state_n = cont_q ? S_RUN : S_IDLE;
      S_WR_STOP:   state_n = S_IDLE;
      S_SNAP_WR:   state_n = S_SNAP_RL;
      S_SNAP_RL:   state_n = S_SNAP_RH;
      S_SNAP_RH:   state_n = S_SNAP_DONE;
      S_SNAP_DONE: state_n = from_run ? S_RUN : S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_comb begin
    tmr.chipselect = 1'b0;
    tmr.write_n    = 1'b1;
    tmr.address    = 3'd0;
    tmr.writedata  = 16'h0000;
    case (state)
      S_WR_PL:   begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd2; tmr.writedata = period_q[15:0]; end
      S_WR_PH:   begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd3; tmr.writedata = period_q[31:16]; end
      S_WR_CTRL: begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd1; tmr.writedata = {13'd0, 1'b1, cont_q, CTRL_ITO}; end
      S_CLR_ST:  begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd0; end
      S_WR_STOP: begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd1; tmr.writedata = 16'h0008; end
      S_SNAP_WR: begin tmr.chipselect = 1'b1; tmr.write_n = 1'b0; tmr.address = 3'd4; end
      S_SNAP_RL: begin tmr.chipselect = 1'b1; tmr.address = 3'd4; end
      S_SNAP_RH: begin tmr.chipselect = 1'b1; tmr.address = 3'd5; end
      default: ;
    endcase
  end

  assign busy       = (state != S_IDLE) && (state != S_RUN);
  assign running    = (state == S_RUN) || (state == S_CLR_ST) ||
                      (from_run && ((state == S_SNAP_WR) || (state == S_SNAP_RL) ||
                                    (state == S_SNAP_RH) || (state == S_SNAP_DONE)));
  assign tick       = (state == S_CLR_ST);
  assign snap_valid = (state == S_SNAP_DONE);
  // The high half arrives in the SNAP_DONE cycle, so forward it to line up with snap_valid.
  assign snap_value = (state == S_SNAP_DONE) ? {tmr.readdata, snap_lo} : snap_q;

endmodule

// File: tb/tb_proyecto3_system_timer_ctrl.sv
// Bench for the timer sequencer: directed literal checks followed by random
// stimulus, all compared every cycle against a bus-transaction queue model.
module tb_proyecto3_system_timer_ctrl;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, snap_req = 1'b0;
  logic [31:0]   period = '0;
  logic          busy, running, tick, snap_valid, err;
  logic [TW-1:0] tick_count;
  logic [31:0]   snap_value;
  logic          irq_set = 1'b0;
  logic [31:0]   snap_src = '0;
  logic [31:0]   snap_reg = '0;
  int            checks = 0, failures = 0;

  proyecto3_system_timer_ctrl_if tmr_if ();

  proyecto3_system_timer_ctrl #(.TICK_W(TW), .CTRL_ITO(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .period(period),
    .continuous(continuous), .snap_req(snap_req), .busy(busy), .running(running),
    .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
    .snap_valid(snap_valid), .err(err), .tmr(tmr_if)
  );

  always #5 clk = ~clk;

  // Timer slave: snapshot latch on snapl write, registered readback, irq until status write.
  initial begin
    tmr_if.irq      = 1'b0;
    tmr_if.readdata = 16'h0000;
  end
  always @(posedge clk) begin
    if (tmr_if.chipselect && !tmr_if.write_n && tmr_if.address == 3'd4)
      snap_reg <= snap_src;
    if (tmr_if.address == 3'd4)      tmr_if.readdata <= snap_reg[15:0];
    else if (tmr_if.address == 3'd5) tmr_if.readdata <= snap_reg[31:16];
    else                             tmr_if.readdata <= 16'($urandom);
    tmr_if.irq <= irq_set ||
                  (tmr_if.irq && !(tmr_if.chipselect && !tmr_if.write_n && tmr_if.address == 3'd0));
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a sequence of bus operations is queued when a request is accepted
  // and one operation is consumed per cycle.
  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        run;
    int          kind;   // 0 plain, 1 status clear, 2 snapshot done, 3 stop
  } op_t;

  op_t   q[$];
  op_t   cur;
  bit    cur_v = 0, m_run = 0, end_run = 0, m_stop_pend = 0, m_err = 0, m_cont = 0;
  int    m_cnt = 0;
  logic [31:0] m_per = '0, m_snap = '0;

  function automatic op_t mk(logic cs, logic wn, logic [2:0] a, logic [15:0] d, logic r, int k);
    op_t o;
    o.cs = cs; o.wn = wn; o.addr = a; o.data = d; o.run = r; o.kind = k;
    return o;
  endfunction

  function automatic void advance();
    if (q.size() > 0) begin
      cur   = q.pop_front();
      cur_v = 1;
      if (cur.kind == 2) m_snap = snap_reg;
    end else begin
      cur_v = 0;
      m_run = end_run;
    end
  endfunction

  function automatic void launch_start();
    m_per  = period;
    m_cont = continuous;
    q.push_back(mk(1, 0, 3'd2, m_per[15:0], 0, 0));
    q.push_back(mk(1, 0, 3'd3, m_per[31:16], 0, 0));
    q.push_back(mk(1, 0, 3'd1, {13'd0, 1'b1, m_cont, 1'b1}, 0, 0));
    end_run = 1;
    advance();
  endfunction

  function automatic void model_step();
    if (reset) begin
      q.delete();
      cur_v = 0; m_run = 0; end_run = 0; m_stop_pend = 0; m_err = 0;
      m_cont = 0; m_cnt = 0; m_per = '0; m_snap = '0;
      return;
    end
    m_err = 0;
    if (cur_v) begin
      if (cur.kind == 1) m_cnt = (m_cnt + 1) % (1 << TW);
      if (cur.kind == 3) m_stop_pend = 0;
      else if (stop)     m_stop_pend = 1;
      advance();
    end else if (m_run && (stop || m_stop_pend)) begin
      q.push_back(mk(1, 0, 3'd1, 16'h0008, 0, 3));
      end_run = 0;
      advance();
    end else if (start) begin
      if (period == 32'd0) m_err = 1;
      else                 launch_start();
    end else if (m_run && tmr_if.irq) begin
      q.push_back(mk(1, 0, 3'd0, 16'h0000, 1, 1));
      end_run = m_cont;
      advance();
    end else if (snap_req) begin
      q.push_back(mk(1, 0, 3'd4, 16'h0000, m_run, 0));
      q.push_back(mk(1, 1, 3'd4, 16'h0000, m_run, 0));
      q.push_back(mk(1, 1, 3'd5, 16'h0000, m_run, 0));
      q.push_back(mk(0, 1, 3'd0, 16'h0000, m_run, 2));
      end_run = m_run;
      advance();
    end
  endfunction

  function automatic logic [31:0] dut_bus();
    return {11'd0, tmr_if.chipselect, tmr_if.write_n, tmr_if.address, tmr_if.writedata};
  endfunction

  function automatic logic [31:0] lit_bus(logic cs, logic wn, logic [2:0] a, logic [15:0] d);
    return {11'd0, cs, wn, a, d};
  endfunction

  always @(negedge clk) begin
    check("m_bus", dut_bus(),
          cur_v ? lit_bus(cur.cs, cur.wn, cur.addr, cur.data) : lit_bus(0, 1, 3'd0, 16'h0));
    check("m_busy", 32'(busy), 32'(cur_v));
    check("m_running", 32'(running), 32'(cur_v ? cur.run : m_run));
    check("m_tick", 32'(tick), 32'(cur_v && cur.kind == 1));
    check("m_tick_count", 32'(tick_count), 32'(m_cnt));
    check("m_snap_valid", 32'(snap_valid), 32'(cur_v && cur.kind == 2));
    check("m_snap_value", snap_value, m_snap);
    check("m_err", 32'(err), 32'(m_err));
    model_step();
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic service_irq();
    irq_set = 1'b1;
    step();
    irq_set = 1'b0;
    step();
    check("svc_tick", 32'(tick), 32'd1);
    step();
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    step();
    check("rst_bus", dut_bus(), lit_bus(0, 1, 3'd0, 16'h0));
    check("rst_busy_running", {busy, running}, 32'd0);
    check("rst_tick_count", 32'(tick_count), 32'd0);

    start = 1'b1; period = 32'h0001_0005; continuous = 1'b1;
    step(); start = 1'b0;
    check("wr_pl", dut_bus(), lit_bus(1, 0, 3'd2, 16'h0005));
    step();
    check("wr_ph", dut_bus(), lit_bus(1, 0, 3'd3, 16'h0001));
    step();
    check("wr_ctrl_cont", dut_bus(), lit_bus(1, 0, 3'd1, 16'h0007));
    check("running_k3", 32'(running), 32'd0);
    step();
    check("running_k4", {busy, running}, 32'd1);

    for (int i = 0; i < 4; i++) begin
      irq_set = 1'b1;
      step(); irq_set = 1'b0;
      step();
      check("clr_write", dut_bus(), lit_bus(1, 0, 3'd0, 16'h0000));
      step();
      check("tick_count_inc", 32'(tick_count), 32'(i + 1));
      check("clr_back_run", {busy, running}, 32'd1);
    end

    snap_src = 32'h00AB_1234; snap_req = 1'b1;
    step(); snap_req = 1'b0;
    step();
    irq_set = 1'b1;
    step(); irq_set = 1'b0;
    step();
    check("snap_valid_k4", 32'(snap_valid), 32'd1);
    check("snap_value", snap_value, 32'h00AB_1234);
    step();
    check("snap_back_run", {snap_valid, running}, 32'd1);
    step();
    check("irq_after_snap", 32'(tick), 32'd1);
    step();

    start = 1'b1; period = 32'h0000_0010; continuous = 1'b1;
    step(); start = 1'b0;
    step(); stop = 1'b1;
    step(); stop = 1'b0;
    check("stop_ctrl_done", dut_bus(), lit_bus(1, 0, 3'd1, 16'h0007));
    step();
    step();
    check("stop_write", dut_bus(), lit_bus(1, 0, 3'd1, 16'h0008));
    check("stop_running", 32'(running), 32'd0);
    step();
    check("stop_idle", {busy, running}, 32'd0);

    start = 1'b1; period = 32'd0;
    step(); start = 1'b0;
    check("err_pulse", 32'(err), 32'd1);
    check("err_no_bus", dut_bus(), lit_bus(0, 1, 3'd0, 16'h0));
    step();
    check("err_one_cycle", 32'(err), 32'd0);

    start = 1'b1; period = 32'd5; continuous = 1'b0;
    step(); start = 1'b0;
    step(); step();
    check("wr_ctrl_oneshot", dut_bus(), lit_bus(1, 0, 3'd1, 16'h0005));
    step();
    service_irq();
    check("oneshot_idle", {busy, running}, 32'd0);
    check("tick_count_6", 32'(tick_count), 32'd6);

    start = 1'b1; period = 32'd7; continuous = 1'b1;
    step(); start = 1'b0;
    step(); step(); step();
    for (int i = 0; i < 10; i++) service_irq();
    check("tick_wrap", 32'(tick_count), 32'd0);

    start = 1'b1;
    step(); start = 1'b0;
    step();
    reset = 1'b1;
    step();
    check("rst_mid_bus", dut_bus(), lit_bus(0, 1, 3'd0, 16'h0));
    check("rst_mid_busy", {busy, running}, 32'd0);
    reset = 1'b0;
    step();

    for (int c = 0; c < 3000; c++) begin
      start      = ($urandom_range(0, 11) == 0);
      period     = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      continuous = 1'($urandom_range(0, 1));
      stop       = ($urandom_range(0, 24) == 0);
      snap_req   = ($urandom_range(0, 7) == 0);
      irq_set    = ($urandom_range(0, 9) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      snap_src   = $urandom;
      step();
    end
    start = 1'b0; stop = 1'b0; snap_req = 1'b0; irq_set = 1'b0; reset = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
